song_player: RTL and testbench

SONG_PLAYER -- requirements
Module: song_player

---
 rtl/song_player.sv | 227 ++++++++++++++++++++++
 tb/tb_song_player.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_player.sv
// -----------------------------------------------------------------------------
// song_player
//
// Plays a song stored in an external note memory. A start request latches the
// requested song number, then each note slot is fetched (one-cycle read
// strobe), loaded (memory data valid), sounded for its programmed number of
// cycles and followed by a silent gap. A zero duration marks the end of a song.
// The last slot (SONG_LEN-1) also ends the song. A one-cycle done pulse is
// emitted on completion.
//
// Parameters
//   SONG_LEN    number of note slots per song (locations 0..SONG_LEN-1)
//   GAP_CYCLES  silent cycles after every note, 0 = no gap
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         one-cycle request to play song_sel (only honoured in IDLE)
//   stop          level, aborts playback back to IDLE without a done pulse
//   pause         level, freezes note/gap timing while high
//   song_sel      requested song, 1..3 (0 is rejected)
//   mem_note      note value returned by the song memory
//   mem_duration  note duration in clk cycles returned by the song memory
//   isread        memory read strobe
//   songnum       song number driven to the memory
//   location      note slot address driven to the memory
//   note_out      currently sounding note
//   note_valid    high while note_out must sound
//   playing       high in every state except IDLE and DONE
//   done          one-cycle completion pulse
//
// Every output is a flop; all next-state values come from one combinational
// block so the registered outputs always agree with the registered state.
// -----------------------------------------------------------------------------
module song_player #(
   parameter int SONG_LEN   = 26,
   parameter int GAP_CYCLES = 5000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        pause,
   input  logic [1:0]  song_sel,
   input  logic [3:0]  mem_note,
   input  logic [25:0] mem_duration,
   output logic        isread,
   output logic [1:0]  songnum,
   output logic [4:0]  location,
   output logic [3:0]  note_out,
   output logic        note_valid,
   output logic        playing,
   output logic        done
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_PLAY  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   localparam logic [4:0]  LAST_LOC = 5'(SONG_LEN - 1);
   localparam logic [25:0] GAP_LOAD = 26'(GAP_CYCLES);
   localparam bit          HAS_GAP  = (GAP_CYCLES != 0);

   logic [2:0]  state_reg,      state_next;
   logic        isread_reg,     isread_next;
   logic [1:0]  songnum_reg,    songnum_next;
   logic [4:0]  location_reg,   location_next;
   logic [3:0]  note_reg,       note_next;
   logic        note_valid_reg, note_valid_next;
   logic        playing_reg,    playing_next;
   logic        done_reg,       done_next;
   logic [25:0] dur_cnt_reg,    dur_cnt_next;
   logic [25:0] gap_cnt_reg,    gap_cnt_next;

   // Set by PLAY (no gap) or GAP when the current slot is finished.
   logic        advance;

   always_comb begin
      state_next      = state_reg;
      isread_next     = 1'b0;
      songnum_next    = songnum_reg;
      location_next   = location_reg;
      note_next       = note_reg;
      note_valid_next = 1'b0;
      done_next       = 1'b0;
      dur_cnt_next    = dur_cnt_reg;
      gap_cnt_next    = gap_cnt_reg;
      advance         = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (start && (song_sel != 2'd0)) begin
               songnum_next  = song_sel;
               location_next = 5'd0;
               isread_next   = 1'b1;
               state_next    = ST_FETCH;
            end
         end

         // The memory registers its data at the end of this cycle.
         ST_FETCH: begin
            state_next = ST_LOAD;
         end

         ST_LOAD: begin
            note_next    = mem_note;
            dur_cnt_next = mem_duration;
            if (mem_duration == 26'd0) begin
               // zero duration is the end-of-song marker
               done_next  = 1'b1;
               state_next = ST_DONE;
            end else begin
               // the first PLAY cycle always sounds; pause only acts in PLAY
               note_valid_next = 1'b1;
               state_next      = ST_PLAY;
            end
         end

         // A cycle counts toward the note only when it actually sounded
         // (note_valid high). Because note_valid is a flop, pause silences the
         // note from the following cycle, and the count of sounding cycles is
         // always exactly the programmed duration.
         ST_PLAY: begin
            if (note_valid_reg) begin
               if (dur_cnt_reg <= 26'd1) begin
                  dur_cnt_next = 26'd0;
                  if (HAS_GAP) begin
                     gap_cnt_next = GAP_LOAD;
                     state_next   = ST_GAP;
                  end else begin
                     advance = 1'b1;
                  end
               end else begin
                  dur_cnt_next    = dur_cnt_reg - 26'd1;
                  note_valid_next = !pause;
               end
            end else begin
               note_valid_next = !pause;
            end
         end

         ST_GAP: begin
            if (!pause) begin
               if (gap_cnt_reg <= 26'd1) begin
                  gap_cnt_next = 26'd0;
                  advance      = 1'b1;
               end else begin
                  gap_cnt_next = gap_cnt_reg - 26'd1;
               end
            end
         end

         ST_DONE: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Move to the next slot, or finish on the last one (no wrap).
      if (advance) begin
         if (location_reg == LAST_LOC) begin
            done_next  = 1'b1;
            state_next = ST_DONE;
         end else begin
            location_next = location_reg + 5'd1;
            isread_next   = 1'b1;
            state_next    = ST_FETCH;
         end
      end

      // Abort overrides everything else: back to IDLE with cleared outputs.
      if (stop && (state_reg != ST_IDLE)) begin
         state_next      = ST_IDLE;
         isread_next     = 1'b0;
         songnum_next    = 2'd0;
         location_next   = 5'd0;
         note_next       = 4'd0;
         note_valid_next = 1'b0;
         done_next       = 1'b0;
         dur_cnt_next    = 26'd0;
         gap_cnt_next    = 26'd0;
      end

      playing_next = (state_next != ST_IDLE) && (state_next != ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         isread_reg     <= 1'b0;
         songnum_reg    <= 2'd0;
         location_reg   <= 5'd0;
         note_reg       <= 4'd0;
         note_valid_reg <= 1'b0;
         playing_reg    <= 1'b0;
         done_reg       <= 1'b0;
         dur_cnt_reg    <= 26'd0;
         gap_cnt_reg    <= 26'd0;
      end else begin
         state_reg      <= state_next;
         isread_reg     <= isread_next;
         songnum_reg    <= songnum_next;
         location_reg   <= location_next;
         note_reg       <= note_next;
         note_valid_reg <= note_valid_next;
         playing_reg    <= playing_next;
         done_reg       <= done_next;
         dur_cnt_reg    <= dur_cnt_next;
         gap_cnt_reg    <= gap_cnt_next;
      end
   end

   assign isread     = isread_reg;
   assign songnum    = songnum_reg;
   assign location   = location_reg;
   assign note_out   = note_reg;
   assign note_valid = note_valid_reg;
   assign playing    = playing_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_song_player.sv
// -----------------------------------------------------------------------------
// tb_song_player
//
// Drives two song_player instances from a shared song table: the main one with
// SONG_LEN=3, GAP_CYCLES=2 and a second one with GAP_CYCLES=0. Expected
// results are derived from the song table: the list of notes that must sound,
// how long each sounds, which slots are fetched and when the song finishes.
// -----------------------------------------------------------------------------
module tb_song_player;

   localparam int SL = 3;
   localparam int GC = 2;

   logic        clk = 1'b0;
   logic        rst, start, stop, pause;
   logic [1:0]  song_sel;

   logic [3:0]  mem_note;
   logic [25:0] mem_duration;
   logic        isread, note_valid, playing, done;
   logic [1:0]  songnum;
   logic [4:0]  location;
   logic [3:0]  note_out;

   logic [3:0]  mem_note_ng;
   logic [25:0] mem_duration_ng;
   logic        isread_ng, note_valid_ng, playing_ng, done_ng;
   logic [1:0]  songnum_ng;
   logic [4:0]  location_ng;
   logic [3:0]  note_out_ng;

   int tbl_note [4][32];
   int tbl_dur  [4][32];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // run monitor
   int t0, first_rd, first_vld, done_n, done_cyc, done_loc, nfetch, note_glitch;
   int f_loc [16];
   int f_sn  [16];
   int vcnt  [16];
   int vnote [16];
   bit vlog  [512];
   int ng_last_v, ng_adj, ng_done_cyc, ng_done_n;

   song_player #(.SONG_LEN(SL), .GAP_CYCLES(GC)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .song_sel(song_sel), .mem_note(mem_note), .mem_duration(mem_duration),
      .isread(isread), .songnum(songnum), .location(location),
      .note_out(note_out), .note_valid(note_valid), .playing(playing), .done(done)
   );

   song_player #(.SONG_LEN(SL), .GAP_CYCLES(0)) dut_ng (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .song_sel(song_sel), .mem_note(mem_note_ng), .mem_duration(mem_duration_ng),
      .isread(isread_ng), .songnum(songnum_ng), .location(location_ng),
      .note_out(note_out_ng), .note_valid(note_valid_ng), .playing(playing_ng), .done(done_ng)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // song memories: one-cycle registered read
   always @(posedge clk) begin
      if (isread) begin
         mem_note     <= 4'(tbl_note[songnum][location]);
         mem_duration <= 26'(tbl_dur[songnum][location]);
      end
      if (isread_ng) begin
         mem_note_ng     <= 4'(tbl_note[songnum_ng][location_ng]);
         mem_duration_ng <= 26'(tbl_dur[songnum_ng][location_ng]);
      end
   end

   always @(negedge clk) begin
      if (isread) begin
         if (nfetch < 16) begin
            f_loc[nfetch] = int'(location);
            f_sn[nfetch]  = int'(songnum);
         end
         nfetch++;
         if (first_rd < 0) first_rd = cyc;
      end
      if (note_valid) begin
         if (first_vld < 0) first_vld = cyc;
         if (nfetch > 0 && nfetch <= 16) begin
            if (vcnt[nfetch-1] == 0) vnote[nfetch-1] = int'(note_out);
            else if (vnote[nfetch-1] != int'(note_out)) note_glitch++;
            vcnt[nfetch-1]++;
         end
         if (!playing) note_glitch++;
      end
      if (cyc - t0 >= 0 && cyc - t0 < 512) vlog[cyc-t0] = note_valid;
      if (done) begin
         done_n++;
         done_cyc = cyc;
         done_loc = int'(location);
      end
      if (note_valid_ng) ng_last_v = cyc;
      if (isread_ng && ng_last_v == cyc - 1) ng_adj++;
      if (done_ng) begin
         ng_done_n++;
         ng_done_cyc = cyc;
      end
   end

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      t0 = cyc; first_rd = -1; first_vld = -1; done_n = 0; done_cyc = -1;
      done_loc = -1; nfetch = 0; note_glitch = 0;
      for (int i = 0; i < 16; i++) begin
         f_loc[i] = -1; f_sn[i] = -1; vcnt[i] = 0; vnote[i] = -1;
      end
      for (int i = 0; i < 512; i++) vlog[i] = 1'b0;
      ng_last_v = -10; ng_adj = 0; ng_done_cyc = -1; ng_done_n = 0;
   endtask

   function automatic int out_vec();
      return int'({isread, songnum, location, note_out, note_valid, playing, done});
   endfunction

   function automatic int ng_vec();
      return int'({isread_ng, songnum_ng, location_ng, note_out_ng, note_valid_ng, playing_ng, done_ng});
   endfunction

   // number of notes that sound before the song ends
   function automatic int exp_k(input int sel);
      for (int i = 0; i < SL; i++)
         if (tbl_dur[sel][i] == 0) return i;
      return SL;
   endfunction

   // cycles from the start request to the done pulse with no pause:
   // one read cycle, then per sounding note read+load+duration+gap, and a
   // final read+load when the song ends on a zero-duration marker
   function automatic int exp_span(input int sel, input int gap);
      int k = exp_k(sel);
      int s = 1;
      for (int i = 0; i < k; i++) s += 2 + tbl_dur[sel][i] + gap;
      if (k < SL) s += 2;
      return s;
   endfunction

   task automatic set_song(input int sel, input int n0, input int d0, input int n1,
                           input int d1, input int n2, input int d2);
      tbl_note[sel][0] = n0; tbl_dur[sel][0] = d0;
      tbl_note[sel][1] = n1; tbl_dur[sel][1] = d1;
      tbl_note[sel][2] = n2; tbl_dur[sel][2] = d2;
   endtask

   // mode 0 plain, 1 random pause, 2 pause over cycles T+4..T+8,
   // 3 random start pulses / song_sel changes while playing
   task automatic run_song(input int sel, input int mode, output int t_start);
      clear_mon();
      start = 1'b1;
      song_sel = 2'(sel);
      t_start = cyc;
      step(1);
      start = 1'b0;
      for (int i = 0; i < 600; i++) begin
         case (mode)
            1: pause = ($urandom_range(0, 2) == 0);
            2: pause = (cyc - t_start >= 4) && (cyc - t_start <= 8);
            3: begin
               start    = ($urandom_range(0, 3) == 0);
               song_sel = 2'($urandom_range(0, 3));
            end
            default: ;
         endcase
         step(1);
         if (done_n > 0) break;
      end
      pause = 1'b0;
      start = 1'b0;
      step(2);
   endtask

   task automatic verify(input int sel, input int t_start, input bit timed);
      int k  = exp_k(sel);
      int nf = (k < SL) ? k + 1 : k;
      check_val("done_cnt", done_n, 1);
      check_val("fetch_cnt", nfetch, nf);
      for (int i = 0; i < nf && i < 16; i++)
         check_val("fetch_addr", f_sn[i] * 32 + f_loc[i], sel * 32 + i);
      for (int i = 0; i < k; i++) begin
         check_val("note_val", vnote[i], tbl_note[sel][i]);
         check_val("note_len", vcnt[i], tbl_dur[sel][i]);
      end
      check_val("note_glitch", note_glitch, 0);
      check_val("done_loc", done_loc, (k < SL) ? k : SL - 1);
      if (timed) begin
         check_val("rd_lat", first_rd, t_start + 1);
         if (k > 0) check_val("vld_lat", first_vld, t_start + 3);
         check_val("done_time", done_cyc, t_start + exp_span(sel, GC));
      end
      check_val("idle_after", int'({playing, isread, note_valid, done}), 0);
   endtask

   initial begin
      int t;
      rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; song_sel = 2'd0;
      for (int s = 0; s < 4; s++)
         for (int i = 0; i < 32; i++) begin
            tbl_note[s][i] = 0;
            tbl_dur[s][i]  = 0;
         end
      clear_mon();
      step(3);
      check_val("rst_main", out_vec(), 0);
      check_val("rst_ng", ng_vec(), 0);
      rst = 1'b0;
      step(1);

      // reference song, also exercises the gap-less instance
      set_song(1, 2, 4, 3, 3, 4, 2);
      run_song(1, 0, t);
      verify(1, t, 1'b1);
      check_val("ng_adj", ng_adj, SL - 1);
      check_val("ng_done_time", ng_done_cyc, t + exp_span(1, 0));

      // 5-cycle pause in the middle of the first 4-cycle note
      run_song(1, 2, t);
      verify(1, t, 1'b0);
      check_val("pause_time", done_cyc - t, exp_span(1, GC) + 5);
      check_val("pause_mute", int'(vlog[6]), 0);
      check_val("pause_before", int'(vlog[3]), 1);

      // end-of-song marker in slot 1
      set_song(2, 5, 3, 6, 0, 7, 2);
      run_song(2, 0, t);
      verify(2, t, 1'b1);

      // stop during the gap after slot 1, then start song 3
      clear_mon();
      start = 1'b1; song_sel = 2'd1; t = cyc;
      step(1);
      start = 1'b0;
      step(13);
      check_val("stop_in_gap", int'({note_valid, isread}), 0);
      check_val("stop_fetches", nfetch, 2);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check_val("stop_outs", out_vec(), 0);
      step(5);
      check_val("stop_no_done", done_n, 0);
      set_song(3, 9, 2, 10, 1, 11, 3);
      run_song(3, 0, t);
      verify(3, t, 1'b1);

      // start with song_sel=0 is ignored
      clear_mon();
      start = 1'b1; song_sel = 2'd0;
      step(1);
      start = 1'b0;
      step(4);
      check_val("sel0_rd", nfetch, 0);
      check_val("sel0_play", int'(playing), 0);

      // start pulses while playing do not restart
      run_song(1, 3, t);
      verify(1, t, 1'b1);

      // reset in the middle of a note
      clear_mon();
      start = 1'b1; song_sel = 2'd1;
      step(1);
      start = 1'b0;
      step(3);
      check_val("pre_rst_vld", int'(note_valid), 1);
      rst = 1'b1;
      step(1);
      check_val("rst_mid", out_vec(), 0);
      rst = 1'b0;
      step(2);

      // randomized songs
      for (int it = 0; it < 10; it++) begin
         int sel  = $urandom_range(1, 3);
         int mode = $urandom_range(0, 1);
         for (int i = 0; i < SL; i++) begin
            tbl_note[sel][i] = $urandom_range(0, 15);
            tbl_dur[sel][i]  = $urandom_range(1, 6);
         end
         if ($urandom_range(0, 3) == 0) tbl_dur[sel][$urandom_range(0, SL - 1)] = 0;
         run_song(sel, mode, t);
         verify(sel, t, mode == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
